// File: rtl/mode_pkg.sv
// Shared definitions for the blink-mode detector: FSM encoding, class codes,
// acceptance windows and nominal half-periods (same values the transmitter uses).
package mode_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_CANDIDATE = 2'd1,
      ST_LOCKED    = 2'd2,
      ST_STATIC    = 2'd3
   } state_t;

   // Class 0 doubles as "invalid"; classes 1..3 map directly onto mode codes.
   localparam logic [1:0] CLS_INVALID = 2'd0;

   localparam int unsigned MODE1_LO = 450;
   localparam int unsigned MODE1_HI = 549;
   localparam int unsigned MODE2_LO = 225;
   localparam int unsigned MODE2_HI = 274;
   localparam int unsigned MODE3_LO = 90;
   localparam int unsigned MODE3_HI = 109;

   localparam int unsigned NOM_HALF1 = 500;
   localparam int unsigned NOM_HALF2 = 250;
   localparam int unsigned NOM_HALF3 = 100;

   // Map a measured half-period onto its class; bounds are inclusive.
   function automatic logic [1:0] classify(input int unsigned v);
      if (v >= MODE1_LO && v <= MODE1_HI) return 2'd1;
      if (v >= MODE2_LO && v <= MODE2_HI) return 2'd2;
      if (v >= MODE3_LO && v <= MODE3_HI) return 2'd3;
      return CLS_INVALID;
   endfunction

endpackage

// File: rtl/mode_detector_sync_edge.sv
// Two-flop synchronizer plus history flop for the asynchronous blink input.
// Ports: SCLK, RST_N (async, active-low), din (async input),
//        edge_c (combinational pulse, high for one cycle per input transition).
module sync_edge (
   input  logic SCLK,
   input  logic RST_N,
   input  logic din,
   output logic edge_c
);

   logic sync1;
   logic sync2;
   logic hist;

   // Synchronizer chain and history flop
   always_ff @(posedge SCLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign edge_c = sync2 ^ hist;

endmodule

// File: rtl/mode_detector.sv
// Measures half-periods of a far-end blink clock and locks onto a mode code
// after two consecutive matching measurements; a long quiet input reads as mode 0.
// Ports: SCLK, RST_N (async, active-low), mode_in (async blink input),
//        mode (locked code), mode_valid, half_period (last measurement), LD (status LEDs).
module mode_detector
   import mode_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 11
) (
   input  logic             SCLK,
   input  logic             RST_N,
   input  logic             mode_in,
   output logic [1:0]       mode,
   output logic             mode_valid,
   output logic [CNT_W-1:0] half_period,
   output logic [15:0]      LD
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q;
   state_t           state_d;
   logic             first_q;
   logic             first_d;
   logic [1:0]       cand_q;
   logic [1:0]       cand_d;
   logic [1:0]       mode_d;
   logic             valid_d;
   logic [CNT_W-1:0] half_d;
   logic [CNT_W-1:0] cnt;
   logic             edge_c;
   logic [1:0]       cls_c;
   logic             timeout_c;

   sync_edge u_sync_edge (
      .SCLK   (SCLK),
      .RST_N  (RST_N),
      .din    (mode_in),
      .edge_c (edge_c)
   );

   assign cls_c     = classify(32'(cnt));
   assign timeout_c = (cnt == CNT_W'(TIMEOUT));

   // State and registered outputs
   always_ff @(posedge SCLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_SEARCH;
         first_q     <= 1'b1;
         cand_q      <= 2'd0;
         mode        <= 2'd0;
         mode_valid  <= 1'b0;
         half_period <= '0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         cand_q      <= cand_d;
         mode        <= mode_d;
         mode_valid  <= valid_d;
         half_period <= half_d;
      end
   end

   // Half-period counter: restarts at 1 on an edge, saturates otherwise
   always_ff @(posedge SCLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (edge_c) begin
         cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // LEDs trail mode/mode_valid by one cycle
   always_ff @(posedge SCLK or negedge RST_N) begin
      if (!RST_N) begin
         LD <= 16'h0000;
      end else begin
         LD <= {11'd0, mode_valid, (mode_valid ? (4'b0001 << mode) : 4'b0000)};
      end
   end

   // Next-state and output decisions; an edge always wins over timeout
   always_comb begin
      state_d = state_q;
      first_d = first_q;
      cand_d  = cand_q;
      mode_d  = mode;
      valid_d = mode_valid;
      half_d  = half_period;

      if (edge_c) begin
         if (first_q) begin
            // Only restarts the measurement (also absorbs a reset-release glitch)
            first_d = 1'b0;
            if (state_q == ST_STATIC) begin
               state_d = ST_SEARCH;
               valid_d = 1'b0;
            end
         end else begin
            half_d = cnt;
            unique case (state_q)
               ST_SEARCH: begin
                  if (cls_c != CLS_INVALID) begin
                     state_d = ST_CANDIDATE;
                     cand_d  = cls_c;
                  end
               end
               ST_CANDIDATE: begin
                  if (cls_c == CLS_INVALID) begin
                     state_d = ST_SEARCH;
                  end else if (cls_c == cand_q) begin
                     state_d = ST_LOCKED;
                     mode_d  = cand_q;
                     valid_d = 1'b1;
                  end else begin
                     cand_d = cls_c;
                  end
               end
               ST_LOCKED: begin
                  if (cls_c == CLS_INVALID) begin
                     state_d = ST_SEARCH;
                     valid_d = 1'b0;
                  end else if (cls_c != mode) begin
                     state_d = ST_CANDIDATE;
                     cand_d  = cls_c;
                     valid_d = 1'b0;
                  end
               end
               ST_STATIC: begin
                  state_d = ST_SEARCH;
                  valid_d = 1'b0;
               end
               default: begin
                  state_d = ST_SEARCH;
               end
            endcase
         end
      end else if (timeout_c) begin
         state_d = ST_STATIC;
         mode_d  = 2'd0;
         valid_d = 1'b1;
         first_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_mode_detector.sv
// Directed bench for mode_detector: timeout, locking, mode changes, window
// boundaries and asynchronous reset behaviour, all against hand-computed values.
module tb_mode_detector;

   localparam int unsigned CNT_W = 11;

   logic             SCLK;
   logic             RST_N;
   logic             mode_in;
   logic [1:0]       mode;
   logic             mode_valid;
   logic [CNT_W-1:0] half_period;
   logic [15:0]      LD;

   int unsigned n_checks;
   int unsigned n_fail;

   mode_detector #(
      .TIMEOUT (1024),
      .CNT_W   (CNT_W)
   ) dut (
      .SCLK        (SCLK),
      .RST_N       (RST_N),
      .mode_in     (mode_in),
      .mode        (mode),
      .mode_valid  (mode_valid),
      .half_period (half_period),
      .LD          (LD)
   );

   initial SCLK = 1'b0;
   always #5 SCLK = ~SCLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Toggle mode_in n cycles after the previous toggle, then advance 5 cycles
   // so the edge (3 cycles) and the LED update (1 more) have settled.
   task automatic hp(input int unsigned n);
      repeat (n - 5) @(posedge SCLK);
      #1 mode_in = ~mode_in;
      repeat (5) @(posedge SCLK);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      RST_N    = 1'b0;
      mode_in  = 1'b0;

      // Reset state
      repeat (3) @(posedge SCLK);
      #1;
      check_val("rst_mode",  32'(mode), 32'd0);
      check_val("rst_valid", 32'(mode_valid), 32'd0);
      check_val("rst_half",  32'(half_period), 32'd0);
      check_val("rst_ld",    32'(LD), 32'h0000);

      // Quiet input: timeout at cnt==1024, mode_valid next cycle, LD one later
      @(negedge SCLK);
      RST_N = 1'b1;
      repeat (1024) @(posedge SCLK);
      #1;
      check_val("pre_timeout_valid", 32'(mode_valid), 32'd0);
      @(posedge SCLK);
      #1;
      check_val("timeout_valid", 32'(mode_valid), 32'd1);
      check_val("timeout_mode",  32'(mode), 32'd0);
      check_val("timeout_ld_lag", 32'(LD), 32'h0000);
      @(posedge SCLK);
      #1;
      check_val("timeout_ld", 32'(LD), 32'h0011);
      repeat (70) @(posedge SCLK);

      // 499-cycle half-periods: first edge ignored, lock on the third
      hp(499);
      check_val("m1_e1_valid", 32'(mode_valid), 32'd0);
      check_val("m1_e1_half",  32'(half_period), 32'd0);
      hp(499);
      check_val("m1_e2_valid", 32'(mode_valid), 32'd0);
      check_val("m1_e2_half",  32'(half_period), 32'd499);
      hp(499);
      check_val("m1_lock_mode",  32'(mode), 32'd1);
      check_val("m1_lock_valid", 32'(mode_valid), 32'd1);
      check_val("m1_lock_half",  32'(half_period), 32'd499);
      check_val("m1_lock_ld",    32'(LD), 32'h0012);
      hp(499);
      check_val("m1_hold_valid", 32'(mode_valid), 32'd1);

      // Switch to mode 3, then 250-cycle half-periods to mode 2
      hp(100);
      check_val("m3_cand_valid", 32'(mode_valid), 32'd0);
      check_val("m3_cand_mode",  32'(mode), 32'd1);
      hp(100);
      check_val("m3_lock_mode", 32'(mode), 32'd3);
      check_val("m3_lock_ld",   32'(LD), 32'h0018);
      hp(250);
      check_val("m2_cand_valid", 32'(mode_valid), 32'd0);
      check_val("m2_cand_mode",  32'(mode), 32'd3);
      hp(250);
      check_val("m2_lock_mode", 32'(mode), 32'd2);
      check_val("m2_lock_ld",   32'(LD), 32'h0014);
      check_val("m2_lock_half", 32'(half_period), 32'd250);

      // Back to mode 1, then an invalid 180 drops to SEARCH keeping mode
      hp(499);
      hp(499);
      check_val("m1b_lock_mode", 32'(mode), 32'd1);
      hp(180);
      check_val("inv_valid", 32'(mode_valid), 32'd0);
      check_val("inv_mode",  32'(mode), 32'd1);
      check_val("inv_half",  32'(half_period), 32'd180);
      check_val("inv_ld4",   32'(LD[4]), 32'd0);

      // Window boundaries
      hp(550);
      hp(550);
      check_val("b550_valid", 32'(mode_valid), 32'd0);
      check_val("b550_half",  32'(half_period), 32'd550);
      hp(449);
      hp(449);
      check_val("b449_valid", 32'(mode_valid), 32'd0);
      hp(90);
      check_val("b90_valid", 32'(mode_valid), 32'd0);
      hp(109);
      check_val("b109_mode",  32'(mode), 32'd3);
      check_val("b109_valid", 32'(mode_valid), 32'd1);
      hp(450);
      check_val("b450_valid", 32'(mode_valid), 32'd0);
      check_val("b450_mode",  32'(mode), 32'd3);
      hp(549);
      check_val("b549_mode",  32'(mode), 32'd1);
      check_val("b549_valid", 32'(mode_valid), 32'd1);
      hp(110);
      check_val("b110_valid", 32'(mode_valid), 32'd0);
      hp(274);
      check_val("b274_valid", 32'(mode_valid), 32'd0);
      hp(225);
      check_val("b225_mode", 32'(mode), 32'd2);
      check_val("b225_ld",   32'(LD), 32'h0014);

      // Asynchronous reset mid-lock, released with mode_in high
      #3;
      RST_N   = 1'b0;
      mode_in = 1'b1;
      #1;
      check_val("arst_mode",  32'(mode), 32'd0);
      check_val("arst_valid", 32'(mode_valid), 32'd0);
      check_val("arst_half",  32'(half_period), 32'd0);
      check_val("arst_ld",    32'(LD), 32'h0000);
      repeat (3) @(posedge SCLK);
      @(negedge SCLK);
      RST_N = 1'b1;
      hp(105);
      check_val("spur_half",  32'(half_period), 32'd100);
      check_val("spur_valid", 32'(mode_valid), 32'd0);
      hp(100);
      check_val("spur_lock_mode", 32'(mode), 32'd3);
      check_val("spur_lock_half", 32'(half_period), 32'd100);

      // Reset released with mode_in low: first real edge is ignored
      RST_N   = 1'b0;
      mode_in = 1'b0;
      repeat (2) @(posedge SCLK);
      @(negedge SCLK);
      RST_N = 1'b1;
      hp(150);
      check_val("re_e1_half",  32'(half_period), 32'd0);
      check_val("re_e1_valid", 32'(mode_valid), 32'd0);
      hp(100);
      check_val("re_e2_half",  32'(half_period), 32'd100);
      check_val("re_e2_valid", 32'(mode_valid), 32'd0);
      hp(100);
      check_val("re_lock_mode",  32'(mode), 32'd3);
      check_val("re_lock_valid", 32'(mode_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
